// File: rtl/dct_pkg.sv
// Shared definitions for the DCT stage-1 butterfly sequencer: defaults,
// width helper, FSM encoding and the level-shift offset.
package dct_pkg;

  localparam int DCT_WIDTH    = 8;
  localparam int DCT_N_POINTS = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dct_state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Offset removed from unsigned samples to centre them on zero.
  function automatic int level_shift_offset(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/dct_butterfly_pair.sv
// One stage-1 butterfly: optional level shift of both samples, then
// sign-extended sum and difference at WIDTH+1 bits (range is exact).
module dct_butterfly_pair
  import dct_pkg::*;
#(
  parameter int WIDTH = DCT_WIDTH
) (
  input  logic                    i_level_shift,
  input  logic        [WIDTH-1:0] i_lo,
  input  logic        [WIDTH-1:0] i_hi,
  output logic signed [WIDTH:0]   o_add,
  output logic signed [WIDTH:0]   o_sub
);

  localparam logic [WIDTH-1:0] OFFSET = WIDTH'(level_shift_offset(WIDTH));

  logic signed [WIDTH-1:0] w_lo;
  logic signed [WIDTH-1:0] w_hi;

  // Unsigned minus half-range wraps to the correct signed value.
  always_comb begin
    w_lo  = i_level_shift ? (i_lo - OFFSET) : i_lo;
    w_hi  = i_level_shift ? (i_hi - OFFSET) : i_hi;
    o_add = {w_lo[WIDTH-1], w_lo} + {w_hi[WIDTH-1], w_hi};
    o_sub = {w_lo[WIDTH-1], w_lo} - {w_hi[WIDTH-1], w_hi};
  end

endmodule

// File: rtl/dct_butterfly_sequencer.sv
// Accepts a full row, registers all N/2 butterfly pairs, then streams them
// out one per handshake under an internal pair counter.
module dct_butterfly_sequencer
  import dct_pkg::*;
#(
  parameter int WIDTH    = DCT_WIDTH,
  parameter int N_POINTS = DCT_N_POINTS
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_in_valid,
  output logic                                o_in_ready,
  input  logic [N_POINTS*WIDTH-1:0]           i_in_data,
  input  logic                                i_level_shift,
  input  logic                                i_rev_order,
  input  logic                                i_abort,
  output logic                                o_out_valid,
  input  logic                                i_out_ready,
  output logic signed [WIDTH:0]               o_out_add_data,
  output logic signed [WIDTH:0]               o_out_sub_data,
  output logic [((clog2(N_POINTS/2) > 1) ? clog2(N_POINTS/2) : 1)-1:0] o_out_index,
  output logic                                o_out_last,
  output logic                                o_busy
);

  localparam int N_PAIRS = N_POINTS / 2;
  localparam int CNT_W   = (clog2(N_PAIRS) > 1) ? clog2(N_PAIRS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAIRS - 1);

  dct_state_e              r_state;
  dct_state_e              w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    r_rev;
  logic                    w_rev_next;
  logic signed [WIDTH:0]   r_add [N_PAIRS];
  logic signed [WIDTH:0]   r_sub [N_PAIRS];
  logic signed [WIDTH:0]   w_add [N_PAIRS];
  logic signed [WIDTH:0]   w_sub [N_PAIRS];
  logic                    w_run;
  logic                    w_last;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_index;

  // Pair i combines sample i with its mirror N-1-i.
  for (genvar gi = 0; gi < N_PAIRS; gi++) begin : g_pair
    dct_butterfly_pair #(.WIDTH(WIDTH)) u_pair (
      .i_level_shift (i_level_shift),
      .i_lo          (i_in_data[gi*WIDTH +: WIDTH]),
      .i_hi          (i_in_data[(N_POINTS-1-gi)*WIDTH +: WIDTH]),
      .o_add         (w_add[gi]),
      .o_sub         (w_sub[gi])
    );
  end

  assign w_run    = (r_state == ST_RUN);
  assign w_last   = w_run && (r_cnt == LAST_CNT);
  // A new row may land on the very edge that retires the last pair.
  assign w_accept = i_in_valid && o_in_ready;
  assign w_index  = r_rev ? (LAST_CNT - r_cnt) : r_cnt;

  // Next state and output decode; abort outranks accept and advance.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rev_next   = r_rev;
    o_in_ready   = (!w_run || (w_last && i_out_ready)) && !i_abort;
    o_out_valid  = w_run;
    o_busy       = w_run;
    o_out_last   = w_last;
    if (i_abort) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else if (w_accept) begin
      w_state_next = ST_RUN;
      w_cnt_next   = '0;
      w_rev_next   = i_rev_order;
    end else if (w_run && i_out_ready) begin
      if (w_last) begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next   = r_cnt + CNT_W'(1);
      end
    end
  end

  // Control state: FSM, pair counter and latched order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rev   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rev   <= w_rev_next;
    end
  end

  // Pair array captures the whole row on accept and survives abort.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_PAIRS; i++) begin
        r_add[i] <= '0;
        r_sub[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < N_PAIRS; i++) begin
        r_add[i] <= w_add[i];
        r_sub[i] <= w_sub[i];
      end
    end
  end

  // Output mux reads only registered state.
  always_comb begin
    o_out_index    = w_index;
    o_out_add_data = r_add[w_index];
    o_out_sub_data = r_sub[w_index];
  end

endmodule

// File: doc/dct_butterfly_sequencer.md
Name: dct_butterfly_sequencer

Overview:
Accepts one N-point row of samples in parallel, optionally level-shifts it, and computes all DCT stage-1 butterfly pairs (x[i]+x[N-1-i], x[i]-x[N-1-i]). It then streams the pairs out one per handshake, driven by an internal pair counter rather than an external select.
It is the parametrised successor of the fixed 8-point, 4-way add/sub pair selector and sits between the row buffer and the 1-D DCT multiply stage. It supports any even N, selectable pair order, back-to-back rows and abort.

Parameters:
WIDTH, 8, sample width in bits; outputs are WIDTH+1 signed.
N_POINTS, 8, points per row; must be even and >=2.
CNT_W, localparam = max(1, clog2(N_POINTS/2)), pair index width.

Ports:
Clk  in  1  clock, rising edge.
Rst_n  in  1  reset, asynchronous, active-low.
In_Valid  in  1  row valid.
In_Ready  out  1  row can be accepted this cycle.
In_Data  in  N_POINTS*WIDTH  packed row; sample i at [i*WIDTH +: WIDTH].
Level_Shift  in  1  1: samples are unsigned, subtract 2^(WIDTH-1); 0: samples are signed two's complement. Sampled with the row.
Rev_Order  in  1  1: emit pairs N/2-1 down to 0; 0: emit 0 up. Sampled with the row.
Abort  in  1  synchronous drop of the current row.
Out_Valid  out  1  pair valid.
Out_Ready  in  1  downstream accepts the pair.
Out_Add_Data  out  WIDTH+1  signed x[i]+x[N-1-i].
Out_Sub_Data  out  WIDTH+1  signed x[i]-x[N-1-i].
Out_Index  out  CNT_W  pair index i of the current output.
Out_Last  out  1  current pair is the final pair of the row.
Busy  out  1  row held (state RUN).

Behaviour:
- Clocking and reset: one clock domain. Rst_n low asynchronously forces the following, regardless of Clk:
  - state IDLE, counter 0, pair registers 0;
  - Out_Valid, Out_Last, Busy = 0;
  - Out_Add_Data, Out_Sub_Data, Out_Index = 0.
- FSM states:
  - IDLE: In_Ready=1, Out_Valid=0.
  - RUN: Out_Valid=1.
- Row accept: happens when In_Valid & In_Ready, at the clock edge.
  - Each sample is level-shifted if Level_Shift=1 (result is a signed WIDTH-bit value).
  - All N/2 sums and differences are computed at WIDTH+1 bits signed with sign extension, and registered into a pair array. No saturation is needed because the result range is exact.
  - Rev_Order is latched. The counter loads 0. The state goes to RUN.
- Latency: row accepted at edge k means the first pair is valid in cycle k+1. With Out_Ready held high, one pair per cycle, so a row drains in N/2 cycles.
- Output mapping: pair index = counter when order is forward, N/2-1-counter when reversed. Out_Add_Data, Out_Sub_Data and Out_Index are a registered-array mux on that index (no combinational path from In_Data). Out_Last = (counter == N/2-1).
- Output holds: Out_Valid & !Out_Ready means all outputs are held stable.
- Advance: Out_Valid & Out_Ready means counter+1. On the last pair:
  - In_Ready=1 in that same cycle (In_Ready = IDLE | (Out_Last & Out_Ready & !Abort)).
  - If In_Valid is also high, the new row loads and RUN continues with counter 0, giving zero bubble.
  - Otherwise the state goes to IDLE.
- Abort: has highest priority after reset. In RUN or IDLE it goes to IDLE and resets the counter; no row is accepted that cycle (In_Ready=0 while Abort=1). Pair registers keep their values, but Out_Valid=0.
- N_POINTS=2: one pair, Out_Last is always 1 in RUN.
- Inputs change while not ready: In_Data, Level_Shift and Rev_Order are ignored when not accepted.

Decomposition:
- Shared package (dct_pkg): the WIDTH/N_POINTS defaults, the clog2 function, the FSM state encoding (IDLE=1'b0, RUN=1'b1), and a level-shift constant function.
- One natural sub-module: dct_butterfly_pair. It is combinational: level-shift plus add/sub for one pair, width WIDTH. It is instantiated N/2 times by generate.

Test Plan:
- Default params, Level_Shift=1, Rev_Order=0, Out_Ready=1, row {255,0,128,128,100,50,130,129} -> cycles k+1..k+4 give (add,sub,idx) = (128,126,0), (-126,-130,1), (-78,78,2), (-28,28,3); Out_Last only on idx 3; then Out_Valid=0.
- Same row with Rev_Order=1 -> idx order 3,2,1,0 with the matching values; Out_Last on idx 0.
- Level_Shift=0 extremes: x0=127,x7=-128 gives pair0 (-1,255); x0=-128,x7=127 gives (-1,-255); x0=x7=-128 gives (-256,0). No wrap.
- Backpressure: Out_Ready toggles 1,0,0,1,... -> outputs stable while Out_Ready=0; exactly 4 pairs, none duplicated or dropped. Then a second row offered with In_Valid high during the last pair -> accepted that edge, its pair0 appears next cycle with no gap.
- Abort asserted on the 2nd pair -> Out_Valid=0 next cycle, In_Ready=1 the following cycle; the next row restarts at idx 0.
- Rst_n pulled low mid-row, asynchronously between edges -> Out_Valid, Busy and Out_Last go 0 immediately; after release In_Ready=1 and a fresh row behaves as in test 1.
